tile_raster_assembler: RTL
==========================

TILE_RASTER_ASSEMBLER -- requirements
Module: tile_raster_assembler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 32, frame width in pixels.
REQ-003 SHALL have parameter IMG_HEIGHT, default 16, frame height in pixels.
REQ-004 SHALL have parameter TILE_WIDTH, default 16, tile width in pixels; IMG_WIDTH is a multiple of it.
REQ-005 SHALL have parameter TILE_HEIGHT, default 16, tile height in pixels; IMG_HEIGHT is a multiple of it.
REQ-006 iClk  input  1  single clock; all state updates on rising edge.
REQ-007 iRst  input  1  reset, asynchronous, active-high.
REQ-008 iData  input  DATA_WIDTH  tile-ordered input pixel.
REQ-009 iValid  input  1  iData valid; pixel accepted when iValid && oReady.
REQ-010 oReady  output  1  block can accept an input pixel (high only in WRITE).
REQ-011 oData  output  DATA_WIDTH  raster-ordered output pixel.
REQ-012 oValid  output  1  oData valid; pixel consumed when oValid && iReady.
REQ-013 iReady  input  1  downstream accepts oData.
REQ-014 oDone  output  1  one-cycle pulse: full frame emitted.

Function
REQ-015 SHALL contain an internal frame buffer of IMG_WIDTH*IMG_HEIGHT words (512 by default), synchronous write, registered read with 1-cycle latency.
REQ-016 SHALL implement states WRITE and READ; reset state is WRITE.
REQ-017 Input order: tiles in raster order of tiles (left to right, then down); within a tile, pixels row-major.
REQ-018 In WRITE, each accepted pixel SHALL be written to address (ty*TILE_HEIGHT+r)*IMG_WIDTH + tx*TILE_WIDTH + c, where (tx,ty) is the tile index and (r,c) the in-tile position.
REQ-019 Counters c, r, tx, ty SHALL advance per accepted pixel: c wraps at TILE_WIDTH-1 and increments r; r wraps at TILE_HEIGHT-1 and increments tx; tx wraps at IMG_WIDTH/TILE_WIDTH-1 and increments ty.
REQ-020 Cycles with iValid low in WRITE SHALL leave all counters and memory unchanged.
REQ-021 On acceptance of the last pixel of the frame, SHALL move to READ on the next edge, with oReady low from that edge.
REQ-022 In READ, iValid and iData SHALL be ignored.
REQ-023 In READ, SHALL read addresses 0..IMG_WIDTH*IMG_HEIGHT-1 sequentially, so the output is raster order.
REQ-024 First read SHALL be issued in the first READ cycle; oValid SHALL rise on the following cycle.
REQ-025 While oValid && !iReady, oData and oValid SHALL hold stable, and the read address SHALL NOT advance.
REQ-026 Under continuous iReady, SHALL emit one pixel per cycle with no bubbles. A one-entry skid or output register handles the BRAM latency.
REQ-027 oDone SHALL pulse for exactly one cycle, in the cycle after the last pixel is consumed.
REQ-028 In that same oDone cycle, the state SHALL be WRITE with all counters zero and oReady high.
REQ-029 oValid SHALL be low whenever no unconsumed pixel is held; it SHALL NOT assert in WRITE.
REQ-030 Address and counter widths SHALL be clog2 of their ranges; no wrap beyond frame size.

Reset
REQ-031 iRst high SHALL, asynchronously: set state to WRITE; clear all counters and read address; set oValid=0, oDone=0, oData=0, oReady=0.
REQ-032 oReady SHALL rise on the first clock edge after iRst deasserts.
REQ-033 Reset mid-WRITE or mid-READ SHALL abort the frame. Partial data is discarded logically, and memory contents are not cleared.

Verification
REQ-034 Full frame, iValid continuous, iReady continuous; input pixel k = k mod 256 -> output raster index 0,1,16,32,511 carry 0,1,0,16,255. 512 outputs, then one oDone pulse.
REQ-035 Input with iValid toggled 1/0 every cycle -> output identical to REQ-034; oReady low exactly after the 512th accept.
REQ-036 iReady held low for 5 cycles after the first oValid -> oData stays 0 and oValid stays 1 for those cycles. The sequence then resumes at index 1 with no loss or duplication.
REQ-037 iRst pulsed after 300 accepted pixels -> oValid stays 0 and oReady rises the next edge. A fresh 512-pixel frame then reassembles correctly.
REQ-038 Iterate over two back-to-back frames with different patterns (k mod 256, then 255 - k mod 256) -> the second frame's output matches its own pattern, and exactly two oDone pulses occur.
REQ-039 iValid high with random iData throughout READ -> output unaffected and oReady stays 0.

Source files
------------

// File: rtl/tile_raster_assembler.sv
// Tile-to-raster reorder buffer: captures one frame of tile-ordered pixels, then
// streams the same frame out in raster order through a one-cycle-latency buffer read.
module tile_raster_assembler #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned IMG_WIDTH   = 32,
  parameter int unsigned IMG_HEIGHT  = 16,
  parameter int unsigned TILE_WIDTH  = 16,
  parameter int unsigned TILE_HEIGHT = 16
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [DATA_WIDTH-1:0] iData,
  input  logic                  iValid,
  output logic                  oReady,
  output logic [DATA_WIDTH-1:0] oData,
  output logic                  oValid,
  input  logic                  iReady,
  output logic                  oDone
);

  localparam int unsigned Depth  = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned TilesX = IMG_WIDTH / TILE_WIDTH;
  localparam int unsigned TilesY = IMG_HEIGHT / TILE_HEIGHT;
  localparam int unsigned AddrW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned ColW   = (TILE_WIDTH > 1) ? $clog2(TILE_WIDTH) : 1;
  localparam int unsigned RowW   = (TILE_HEIGHT > 1) ? $clog2(TILE_HEIGHT) : 1;
  localparam int unsigned TxW    = (TilesX > 1) ? $clog2(TilesX) : 1;
  localparam int unsigned TyW    = (TilesY > 1) ? $clog2(TilesY) : 1;

  localparam logic [ColW-1:0]  ColLast  = ColW'(TILE_WIDTH - 1);
  localparam logic [RowW-1:0]  RowLast  = RowW'(TILE_HEIGHT - 1);
  localparam logic [TxW-1:0]   TxLast   = TxW'(TilesX - 1);
  localparam logic [TyW-1:0]   TyLast   = TyW'(TilesY - 1);
  localparam logic [AddrW-1:0] AddrLast = AddrW'(Depth - 1);

  typedef enum logic [0:0] {StWrite, StRead} state_e;

  state_e                state_q, state_d;
  logic [ColW-1:0]       col_q, col_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [TxW-1:0]        tx_q, tx_d;
  logic [TyW-1:0]        ty_q, ty_d;
  logic [AddrW-1:0]      raddr_q, raddr_d;
  logic                  rd_all_q, rd_all_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem [Depth];

  logic             accept;
  logic             frame_in_last;
  logic             rd_en;
  logic             out_last;
  logic [AddrW-1:0] wr_addr;

  assign accept        = (state_q == StWrite) && ready_q && iValid;
  assign frame_in_last = (col_q == ColLast) && (row_q == RowLast) &&
                         (tx_q == TxLast) && (ty_q == TyLast);
  // The read register doubles as the output register: only refill it when empty or draining.
  assign rd_en         = (state_q == StRead) && !rd_all_q && (!valid_q || iReady);
  assign out_last      = (state_q == StRead) && rd_all_q && valid_q && iReady;
  assign wr_addr       = AddrW'((32'(ty_q) * TILE_HEIGHT + 32'(row_q)) * IMG_WIDTH +
                                32'(tx_q) * TILE_WIDTH + 32'(col_q));

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    tx_d     = tx_q;
    ty_d     = ty_q;
    raddr_d  = raddr_q;
    rd_all_d = rd_all_q;
    ready_d  = 1'b0;
    valid_d  = valid_q;
    done_d   = 1'b0;

    unique case (state_q)
      StWrite: begin
        ready_d = 1'b1;
        if (accept) begin
          if (col_q == ColLast) begin
            col_d = '0;
            if (row_q == RowLast) begin
              row_d = '0;
              if (tx_q == TxLast) begin
                tx_d = '0;
                ty_d = (ty_q == TyLast) ? '0 : ty_q + TyW'(1);
              end else begin
                tx_d = tx_q + TxW'(1);
              end
            end else begin
              row_d = row_q + RowW'(1);
            end
          end else begin
            col_d = col_q + ColW'(1);
          end
          if (frame_in_last) begin
            state_d = StRead;
            ready_d = 1'b0;
          end
        end
      end
      StRead: begin
        if (rd_en) begin
          valid_d = 1'b1;
          if (raddr_q == AddrLast) begin
            raddr_d  = '0;
            rd_all_d = 1'b1;
          end else begin
            raddr_d = raddr_q + AddrW'(1);
          end
        end else if (valid_q && iReady) begin
          valid_d = 1'b0;
        end
        if (out_last) begin
          state_d  = StWrite;
          ready_d  = 1'b1;
          done_d   = 1'b1;
          valid_d  = 1'b0;
          rd_all_d = 1'b0;
        end
      end
      default: state_d = StWrite;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= StWrite;
      col_q    <= '0;
      row_q    <= '0;
      tx_q     <= '0;
      ty_q     <= '0;
      raddr_q  <= '0;
      rd_all_q <= 1'b0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      tx_q     <= tx_d;
      ty_q     <= ty_d;
      raddr_q  <= raddr_d;
      rd_all_q <= rd_all_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  // Frame storage is never reset; an aborted frame is simply overwritten by the next one.
  always_ff @(posedge iClk) begin
    if (accept) begin
      mem[wr_addr] <= iData;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= mem[raddr_q];
    end
  end

  assign oReady = ready_q;
  assign oValid = valid_q;
  assign oData  = rdata_q;
  assign oDone  = done_q;

endmodule
